screen_sequencer: RTL

Top-level screen sequencer sitting directly downstream of `start_screen`. It consumes `state_1_over` and the one-cycle `btnc_pressed` pulse and walks the game through START, COUNTDOWN, CAPTURE and SHOW screens. It derives a once-per-frame tick from the VGA counters and drives the enables and countdown digit used by the screen renderers and the camera capture path.

---
 rtl/screen_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Purpose: top-level game sequencer (START -> COUNTDOWN -> CAPTURE -> SHOW) paced by a per-frame tick.
// Latency: every output is registered; a transition sampled at edge N is visible on the outputs after edge N.
// Backpressure: none; inputs are pulses/levels sampled every cycle, capture_done is waited on with a timeout.
//
// Ports:
//   clk_in, rst_in          clock and synchronous active-high reset
//   hcount_in, vcount_in    VGA raster position; (0,0) marks the start of a frame
//   state_1_over            level from start_screen, sampled only in START
//   btnc_pressed            one-cycle button pulse (abort, only with SCREEN_SEQ_ABORT_EN)
//   capture_done            one-cycle pulse from the capture path
//   state_out               START=0, COUNTDOWN=1, CAPTURE=2, SHOW=3
//   start_en                high while in START
//   capture_trigger         one-cycle pulse in the first cycle of CAPTURE
//   countdown_sec           seconds remaining in COUNTDOWN/SHOW, 0 otherwise
//   frame_tick              one-cycle pulse per frame
//   capture_err             sticky flag: the last capture timed out
//
// Optional feature macro: SCREEN_SEQ_ABORT_EN -- button aborts COUNTDOWN/SHOW back to START.

module screen_sequencer #(
    parameter int FRAMES_PER_SEC      = 60,
    parameter int COUNTDOWN_SEC       = 3,
    parameter int SHOW_SEC            = 5,
    parameter int CAPTURE_TIMEOUT_SEC = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        state_1_over,
    input  logic        btnc_pressed,
    input  logic        capture_done,
    output logic [2:0]  state_out,
    output logic        start_en,
    output logic        capture_trigger,
    output logic [3:0]  countdown_sec,
    output logic        frame_tick,
    output logic        capture_err
);

    localparam int SUB_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX    = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [3:0]       CD_LOAD    = 4'(COUNTDOWN_SEC);
    localparam logic [3:0]       SHOW_LOAD  = 4'(SHOW_SEC);
    localparam logic [3:0]       TO_LOAD    = 4'(CAPTURE_TIMEOUT_SEC);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHOW      = 3'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_nxt;
    logic [3:0]       sec;
    logic [3:0]       sec_nxt;
    logic             err_nxt;
    logic             raw;
    logic             raw_d;
    logic             wrap;
    logic             last_wrap;
    logic             abort;

    // Raster origin; edge-detected so a held (0,0) yields a single tick.
    assign raw = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // frame_tick is the registered tick, so the counters advance one cycle after it is raised.
    assign wrap      = frame_tick && (sub == SUB_MAX);
    assign last_wrap = wrap && (sec == 4'd1);

`ifdef SCREEN_SEQ_ABORT_EN
    assign abort = btnc_pressed && ((state == ST_COUNTDOWN) || (state == ST_SHOW));
`else
    logic unused_btnc;
    assign unused_btnc = btnc_pressed;
    assign abort       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sub_nxt   = sub;
        sec_nxt   = sec;
        err_nxt   = capture_err;

        // Time only advances in the timed states; START just holds the counters.
        if ((state != ST_START) && frame_tick) begin
            if (sub == SUB_MAX) begin
                sub_nxt = '0;
                if (sec != 4'd0) begin
                    sec_nxt = sec - 4'd1;
                end
            end else begin
                sub_nxt = sub + 1'b1;
            end
        end

        // Loads on entry overwrite the counting above, so a tick on the entry edge is dropped.
        case (state)
            ST_START: begin
                if (state_1_over) begin
                    state_nxt = ST_COUNTDOWN;
                    sec_nxt   = CD_LOAD;
                    sub_nxt   = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (abort) begin
                    state_nxt = ST_START;
                end else if (last_wrap) begin
                    state_nxt = ST_CAPTURE;
                    sec_nxt   = TO_LOAD;
                    sub_nxt   = '0;
                end
            end
            ST_CAPTURE: begin
                // capture_done takes priority over a coincident timeout.
                if (capture_done) begin
                    state_nxt = ST_SHOW;
                    sec_nxt   = SHOW_LOAD;
                    sub_nxt   = '0;
                    err_nxt   = 1'b0;
                end else if (last_wrap) begin
                    state_nxt = ST_START;
                    err_nxt   = 1'b1;
                end
            end
            ST_SHOW: begin
                if (abort || last_wrap) begin
                    state_nxt = ST_START;
                end
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ST_START;
            sub             <= '0;
            sec             <= 4'd0;
            raw_d           <= 1'b0;
            frame_tick      <= 1'b0;
            start_en        <= 1'b1;
            capture_trigger <= 1'b0;
            countdown_sec   <= 4'd0;
            capture_err     <= 1'b0;
        end else begin
            raw_d           <= raw;
            frame_tick      <= raw & ~raw_d;
            state           <= state_nxt;
            sub             <= sub_nxt;
            sec             <= sec_nxt;
            start_en        <= (state_nxt == ST_START);
            capture_trigger <= (state == ST_COUNTDOWN) && (state_nxt == ST_CAPTURE);
            countdown_sec   <= ((state_nxt == ST_COUNTDOWN) || (state_nxt == ST_SHOW)) ? sec_nxt : 4'd0;
            capture_err     <= err_nxt;
        end
    end

    assign state_out = state;

endmodule
